// File: rtl/smart_light_ctrl.sv
// smart_light_ctrl: occupancy/ambient light controller with manual override and a
// hold-off timer that keeps the light on for HOLD_CYCLES cycles after demand drops.
// Optional feature macro: PRESENCE_DEBOUNCE_EN (two-edge presence qualification).
//
// Handshake/timing: there is no valid/ready handshake; L, P and O are level inputs
// sampled on every rising clk edge, and X/state/hold_cnt are registered so that
// an input sampled at edge n is visible on the outputs right after edge n.
module smart_light_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMER_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               L,
  input  logic               P,
  input  logic               O,
  output logic               X,
  output logic [1:0]         state,
  output logic [TIMER_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_HOLD   = 2'b10,
    S_FORCE  = 2'b11
  } state_t;

  // Reload value: the HOLD state counts HOLD_CYCLES-1 down to 0 inclusive.
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] hold_cnt_q, hold_cnt_d;
  logic               x_q, x_d;
  logic               pe;
  logic               demand;

`ifdef PRESENCE_DEBOUNCE_EN
  logic p_q, p_d;

  // Next value of the presence history bit is simply the current sample.
  always_comb begin
    p_d = P;
  end

  // Presence history register used to require two consecutive high samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 1'b0;
    end else begin
      p_q <= p_d;
    end
  end

  assign pe = P & p_q;
`else
  assign pe = P;
`endif

  assign demand = L & pe;

  // Next-state, hold counter and light output; override beats everything.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (O) begin
      state_d    = S_FORCE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_cnt_d = '0;
          if (demand) begin
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          hold_cnt_d = '0;
          if (!demand) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          // Demand wins over expiry when both happen on the same edge.
          if (demand) begin
            state_d    = S_ACTIVE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == '0) begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        S_FORCE: begin
          // O is already known low here.
          if (demand) begin
            state_d    = S_ACTIVE;
            hold_cnt_d = '0;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        default: begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
    x_d = (state_d != S_IDLE);
  end

  // FSM register with registered light output; reset aborts any hold/force.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      x_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      x_q        <= x_d;
    end
  end

  assign X        = x_q;
  assign state    = state_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_smart_light_ctrl.sv
// Testbench for smart_light_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a "time since last trigger" model. Two instances are
// exercised in lockstep: HOLD_CYCLES=4 and the HOLD_CYCLES=1 boundary.
module tb_smart_light_ctrl;

  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic L = 1'b0, P = 1'b0, O = 1'b0;

  always #5 clk = ~clk;

  logic          x0, x1;
  logic [1:0]    st0, st1;
  logic [TW-1:0] cnt0, cnt1;

  smart_light_ctrl #(.HOLD_CYCLES(4), .TIMER_W(TW)) dut0 (
    .clk(clk), .rst_n(rst_n), .L(L), .P(P), .O(O),
    .X(x0), .state(st0), .hold_cnt(cnt0)
  );

  smart_light_ctrl #(.HOLD_CYCLES(1), .TIMER_W(TW)) dut1 (
    .clk(clk), .rst_n(rst_n), .L(L), .P(P), .O(O),
    .X(x1), .state(st1), .hold_cnt(cnt1)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The light follows the most recent "trigger" edge (O or demand sampled high).
  // At a trigger edge: FORCE if O else ACTIVE. k edges after the last trigger with
  // no new trigger: HOLD with counter HOLD-k while k <= HOLD, otherwise IDLE.
  int HOLDS [2] = '{4, 1};
  int since [2];
  int m_st  [2];
  int m_cnt [2];
  bit p_prev;

  always @(posedge clk or negedge rst_n) begin
    bit pe, d;
    int s;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        since[i] <= -1;
        m_st[i]  <= 0;
        m_cnt[i] <= 0;
      end
      p_prev <= 1'b0;
    end else begin
`ifdef PRESENCE_DEBOUNCE_EN
      pe = P && p_prev;
`else
      pe = P;
`endif
      d = L && pe;
      for (int i = 0; i < 2; i++) begin
        s = since[i];
        if (O || d) begin
          s = 0;
          m_st[i]  <= O ? 3 : 1;
          m_cnt[i] <= 0;
        end else begin
          if (s >= 0 && s <= HOLDS[i]) s = s + 1;
          if (s >= 1 && s <= HOLDS[i]) begin
            m_st[i]  <= 2;
            m_cnt[i] <= HOLDS[i] - s;
          end else begin
            m_st[i]  <= 0;
            m_cnt[i] <= 0;
          end
        end
        since[i] <= s;
      end
      p_prev <= P;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m0_state", int'(st0),  m_st[0]);
      chk("m0_cnt",   int'(cnt0), m_cnt[0]);
      chk("m0_x",     int'(x0),   int'(m_st[0] != 0));
      chk("m1_state", int'(st1),  m_st[1]);
      chk("m1_cnt",   int'(cnt1), m_cnt[1]);
      chk("m1_x",     int'(x1),   int'(m_st[1] != 0));
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs away from the edge, then advance one edge and settle 1ns.
  task automatic step(input logic l, input logic p, input logic o);
    L = l; P = p; O = o;
    @(posedge clk);
    #1;
  endtask

  task automatic exp0(input string name, input int x, input int st, input int cnt);
    chk({name, "_x"},   int'(x0),   x);
    chk({name, "_st"},  int'(st0),  st);
    chk({name, "_cnt"}, int'(cnt0), cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    L = 0; P = 0; O = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    exp0("reset", 0, 0, 0);
    cmp_en = 1'b1;

`ifndef PRESENCE_DEBOUNCE_EN
    // Demand from edge 1 -> ACTIVE after edge 1.
    step(1, 1, 0);
    exp0("first_edge", 1, 1, 0);
    step(1, 1, 0);
    // Presence drops: HOLD counting 3,2,1,0 then IDLE.
    step(1, 0, 0); exp0("hold3", 1, 2, 3);
    step(1, 0, 0); exp0("hold2", 1, 2, 2);
    step(1, 0, 0); exp0("hold1", 1, 2, 1);
    step(1, 0, 0); exp0("hold0", 1, 2, 0);
    step(1, 0, 0); exp0("hold_exp", 0, 0, 0);
    // Re-trigger while hold_cnt=2.
    step(1, 1, 0); exp0("retrig_act", 1, 1, 0);
    step(1, 0, 0); exp0("retrig_h3", 1, 2, 3);
    step(1, 0, 0); exp0("retrig_h2", 1, 2, 2);
    step(1, 1, 0); exp0("retrig_back", 1, 1, 0);
`else
    // Single-cycle presence glitch must not light the lamp.
    step(1, 1, 0); exp0("glitch_e1", 0, 0, 0);
    step(1, 0, 0); exp0("glitch_e2", 0, 0, 0);
    step(1, 1, 0); exp0("deb_first", 0, 0, 0);
    step(1, 1, 0); exp0("deb_second", 1, 1, 0);
`endif

    // Drain to IDLE, then a 3-cycle override pulse with no ambient demand.
    repeat (6) step(0, 0, 0);
    exp0("pre_force", 0, 0, 0);
    begin
      int lit;
      lit = 0;
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 1);
        exp0("force", 1, 3, 0);
        lit += int'(x0);
      end
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 0);
        exp0("force_hold", 1, 2, 3 - i);
        if (i == 0) begin
          chk("h1_hold_st", int'(st1), 2);
          chk("h1_hold_cnt", int'(cnt1), 0);
        end
        if (i == 1) chk("h1_idle_st", int'(st1), 0);
        lit += int'(x0);
      end
      step(0, 0, 0);
      exp0("force_end", 0, 0, 0);
      chk("force_lit_cycles", lit, 7);
    end

    // Asynchronous reset in the middle of a hold (counter at 2).
    step(1, 1, 1);
    step(1, 0, 0); exp0("pre_rst_h3", 1, 2, 3);
    step(1, 0, 0); exp0("pre_rst_h2", 1, 2, 2);
    #2 rst_n = 1'b0;
    #1 exp0("async_rst", 0, 0, 0);
    #1 rst_n = 1'b1;
    step(1, 0, 0); exp0("no_resume", 0, 0, 0);

    // Randomized phase with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      logic l, p, o;
      l = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 2) != 0);
      o = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) p = 1'b0;
      step(l, p, o);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
